regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wr_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 86 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester ids for the register-file write arbiter
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback requests, reservation and register-file write bundle
interface regfile_wr_arbiter_if;
  import regfile_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]   alu_data;

  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;

  logic                rsv_en;
  logic [ADDR_W-1:0]   rsv_addr;
  logic [NUM_REGS-1:0] busy;
  logic                rsv_collision;

  logic                rf_write_en;
  logic [ADDR_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0]   rf_wr_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output rsv_en, rsv_addr,
    input  alu_ready, mem_ready, busy, rsv_collision,
    input  rf_write_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  rsv_en, rsv_addr,
    output alu_ready, mem_ready, busy, rsv_collision,
    output rf_write_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grants
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_id_t last_grant;

  // On a tie the source that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant == REQ_MEM)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_MEM;
    end else if (advance) begin
      last_grant <= gnt[0] ? REQ_ALU : REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the register-file write port between ALU and load paths, tracks pending writes
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);

  logic [1:0]          gnt;
  logic                alu_acc;
  logic                mem_acc;
  logic                accept;
  logic                retire_hit;
  logic                collide;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                coll_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.mem_valid, bus.alu_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  // Grants are masked during reset so no requester sees an accept.
  assign bus.alu_ready = gnt[0] & rst_n;
  assign bus.mem_ready = gnt[1] & rst_n;

  assign alu_acc = bus.alu_valid & bus.alu_ready;
  assign mem_acc = bus.mem_valid & bus.mem_ready;
  assign accept  = alu_acc | mem_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= accept;
      if (alu_acc) begin
        waddr_q <= bus.alu_addr;
        wdata_q <= bus.alu_data;
      end else if (mem_acc) begin
        waddr_q <= bus.mem_addr;
        wdata_q <= bus.mem_data;
      end
    end
  end

  // Reservation is applied after retirement so a same-edge re-reserve keeps the bit set.
  always_comb begin
    busy_nxt = busy_q;
    if (wen_q) begin
      busy_nxt[waddr_q] = 1'b0;
    end
    if (bus.rsv_en) begin
      busy_nxt[bus.rsv_addr] = 1'b1;
    end
  end

  assign retire_hit = wen_q && (waddr_q == bus.rsv_addr);
  assign collide    = bus.rsv_en && busy_q[bus.rsv_addr] && !retire_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      coll_q <= collide;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.rsv_collision = coll_q;
  assign bus.rf_write_en   = wen_q;
  assign bus.rf_wr_addr    = waddr_q;
  assign bus.rf_wr_data    = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for the register-file write arbiter
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t                 aq[$];
  wr_t                 mq[$];
  wr_t                 sb[$];
  req_id_t             m_last = REQ_MEM;
  logic [NUM_REGS-1:0] m_busy = '0;
  logic                m_coll = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.alu_valid = (aq.size() != 0);
    bus.mem_valid = (mq.size() != 0);
    if (aq.size() != 0) begin
      bus.alu_addr = aq[0].addr;
      bus.alu_data = aq[0].data;
    end
    if (mq.size() != 0) begin
      bus.mem_addr = mq[0].addr;
      bus.mem_data = mq[0].data;
    end
  endtask

  // Checks one cycle at the falling edge, advances the model, then re-drives after the rising edge.
  task automatic tick();
    logic ga;
    logic gm;
    logic wen;
    wr_t  e;
    @(negedge clk);
    ga = bus.alu_valid && (!bus.mem_valid || m_last == REQ_MEM);
    gm = bus.mem_valid && !ga;
    chk("alu_ready", bus.alu_ready, ga);
    chk("mem_ready", bus.mem_ready, gm);
    wen = (sb.size() != 0);
    e = '0;
    chk("rf_write_en", bus.rf_write_en, wen);
    if (wen) begin
      e = sb.pop_front();
      chk("rf_wr_addr", bus.rf_wr_addr, e.addr);
      chk("rf_wr_data", bus.rf_wr_data, e.data);
    end
    chk("busy", bus.busy, m_busy);
    chk("rsv_collision", bus.rsv_collision, m_coll);
    m_coll = bus.rsv_en && m_busy[bus.rsv_addr] && !(wen && e.addr == bus.rsv_addr);
    if (wen) m_busy[e.addr] = 1'b0;
    if (bus.rsv_en) m_busy[bus.rsv_addr] = 1'b1;
    if (ga) begin
      sb.push_back(aq.pop_front());
      m_last = REQ_ALU;
    end
    if (gm) begin
      sb.push_back(mq.pop_front());
      m_last = REQ_MEM;
    end
    @(posedge clk);
    #1;
    bus.rsv_en = 1'b0;
    drive();
  endtask

  task automatic reserve(input logic [ADDR_W-1:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
    tick();
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.rsv_en    = 1'b0;
    bus.rsv_addr  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ALU-only write to a reserved register
    reserve(3'd3);
    aq.push_back(wr_t'{3'd3, 8'h5A});
    drive();
    tick();
    tick();
    tick();

    // Both sources valid: grants must alternate
    for (int i = 0; i < 4; i++) begin
      aq.push_back(wr_t'{3'(i), 8'(8'h10 + i)});
      mq.push_back(wr_t'{3'(i + 4), 8'(8'hA0 + i)});
    end
    drive();
    repeat (10) tick();
    chk("alt_drained", aq.size() + mq.size() + sb.size(), 0);

    // MEM-only write at the top address and all-ones data
    mq.push_back(wr_t'{3'd7, 8'hFF});
    drive();
    repeat (3) tick();

    // Reserve R5 on the edge its write retires
    reserve(3'd5);
    aq.push_back(wr_t'{3'd5, 8'h55});
    drive();
    tick();
    reserve(3'd5);
    tick();
    chk("busy5_kept", bus.busy[5], 1'b1);
    chk("busy5_no_coll", bus.rsv_collision, 1'b0);

    // Double reservation of R2
    reserve(3'd2);
    reserve(3'd2);
    chk("coll_pulse", bus.rsv_collision, 1'b1);
    tick();
    chk("coll_single", bus.rsv_collision, 1'b0);
    chk("busy2_kept", bus.busy[2], 1'b1);

    aq.push_back(wr_t'{3'd5, 8'h01});
    aq.push_back(wr_t'{3'd2, 8'h02});
    drive();
    repeat (4) tick();

    // Asynchronous reset with a write in flight
    reserve(3'd0);
    reserve(3'd7);
    aq.push_back(wr_t'{3'd1, 8'h11});
    drive();
    tick();
    chk("pre_wen", bus.rf_write_en, 1'b1);
    chk("pre_busy", bus.busy, 8'h81);
    aq.push_back(wr_t'{3'd4, 8'h44});
    mq.push_back(wr_t'{3'd6, 8'h66});
    drive();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wen", bus.rf_write_en, 1'b0);
    chk("rst_addr", bus.rf_wr_addr, 0);
    chk("rst_data", bus.rf_wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_coll", bus.rsv_collision, 1'b0);
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    sb.delete();
    m_busy = '0;
    m_coll = 1'b0;
    m_last = REQ_MEM;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("tie_alu_first", bus.alu_ready, 1'b1);
    repeat (4) tick();
    chk("final_drained", aq.size() + mq.size() + sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
